// File: rtl/wb_pattern_gen.sv
// wb_pattern_gen: Wishbone master that fills a word region with a test
// pattern, with optional readback check, incrementing bursts and ack timeout.
module wb_pattern_gen #(
  parameter int ADDRESS_WIDTH = 16,
  parameter int DATA_WIDTH = 8,
  parameter int DATA_BYTES = DATA_WIDTH / 8,
  parameter int BASE_ADDR = 0,
  parameter int LENGTH = 256,
  parameter int BURST_LEN = 4,
  parameter logic [DATA_WIDTH-1:0] LFSR_TAPS = DATA_WIDTH'(8'hB8),
  parameter int TIMEOUT = 255
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     start_i,
  input  logic [1:0]               mode_i,
  input  logic                     verify_i,
  input  logic [DATA_WIDTH-1:0]    seed_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     error_o,
  output logic [15:0]              err_count_o,
  output logic [ADDRESS_WIDTH-1:0] adr_o,
  input  logic [DATA_WIDTH-1:0]    dat_i,
  output logic [DATA_WIDTH-1:0]    dat_o,
  output logic                     we_o,
  output logic [DATA_BYTES-1:0]    sel_o,
  output logic                     stb_o,
  input  logic                     cyc_i,
  output logic                     cyc_o,
  input  logic                     ack_i,
  output logic [2:0]               cti_o
);

  localparam int OW = ADDRESS_WIDTH + 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [OW-1:0] LEN = OW'(LENGTH);
  localparam logic [OW-1:0] LAST = OW'(LENGTH - 1);
  localparam logic [OW-1:0] BLEN = OW'(BURST_LEN);
  localparam logic [ADDRESS_WIDTH-1:0] BASE = ADDRESS_WIDTH'(BASE_ADDR);
  localparam logic [TW-1:0] TO_LIM = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ARB, S_BUS, S_GAP, S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [1:0]            mode_q;
  logic                  verify_q;
  logic                  rd_q;
  logic [DATA_WIDTH-1:0] init_q, pat_q;
  logic [OW-1:0]         off_q, left_q;
  logic                  burst_q;
  logic [TW-1:0]         to_cnt_q;
  logic                  cyc_q, stb_q, we_q;
  logic                  error_q;
  logic [15:0]           err_cnt_q;

  logic [OW-1:0]         remain, blen;
  logic                  grant, beat, burst_end;
  logic                  last_word, to_hit, mismatch;
  logic [DATA_WIDTH-1:0] pat_nx, init_nx;

  assign remain    = LEN - off_q;
  assign blen      = (remain < BLEN) ? remain : BLEN;
  assign grant     = (state_q == S_ARB || state_q == S_GAP) && !cyc_i;
  assign beat      = (state_q == S_BUS) && ack_i;
  assign burst_end = beat && (left_q == OW'(1));
  assign last_word = (off_q == LAST);
  assign to_hit    = (state_q == S_BUS) && !ack_i
                   && (to_cnt_q == TO_LIM);
  assign mismatch  = rd_q && (dat_i != pat_q);

  // Pattern for the next offset, derived from the current one.
  always_comb begin
    pat_nx = pat_q;
    case (mode_q)
      2'd0: pat_nx = pat_q + DATA_WIDTH'(1);
      2'd1: pat_nx = ~pat_q;
      2'd2: pat_nx = (pat_q >> 1)
                   ^ (pat_q[0] ? LFSR_TAPS : '0);
      default: pat_nx = pat_q;
    endcase
  end

  always_comb begin
    init_nx = seed_i;
    case (mode_i)
      2'd1: init_nx = {DATA_BYTES{8'h55}} ^ seed_i;
      2'd2: init_nx = (seed_i == '0) ? DATA_WIDTH'(1)
                                     : seed_i;
      default: init_nx = seed_i;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (start_i) state_d = S_ARB;
      S_ARB:  if (grant) state_d = S_BUS;
      S_GAP:  state_d = grant ? S_BUS : S_ARB;
      S_BUS: begin
        if (to_hit)
          state_d = S_DONE;
        else if (burst_end)
          state_d = (last_word && (rd_q || !verify_q))
                  ? S_DONE : S_GAP;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mode_q    <= '0;
      verify_q  <= 1'b0;
      rd_q      <= 1'b0;
      init_q    <= '0;
      pat_q     <= '0;
      off_q     <= '0;
      left_q    <= '0;
      burst_q   <= 1'b0;
      to_cnt_q  <= '0;
      cyc_q     <= 1'b0;
      stb_q     <= 1'b0;
      we_q      <= 1'b0;
      error_q   <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      if (state_q == S_IDLE && start_i) begin
        mode_q    <= mode_i;
        verify_q  <= verify_i;
        init_q    <= init_nx;
        pat_q     <= init_nx;
        off_q     <= '0;
        rd_q      <= 1'b0;
        error_q   <= 1'b0;
        err_cnt_q <= '0;
      end
      if (grant) begin
        cyc_q    <= 1'b1;
        stb_q    <= 1'b1;
        we_q     <= !rd_q;
        left_q   <= blen;
        burst_q  <= blen > OW'(1);
        to_cnt_q <= '0;
      end
      if (beat) begin
        to_cnt_q <= '0;
        off_q    <= off_q + OW'(1);
        pat_q    <= pat_nx;
        left_q   <= left_q - OW'(1);
        if (mismatch) begin
          error_q <= 1'b1;
          if (err_cnt_q != '1)
            err_cnt_q <= err_cnt_q + 16'd1;
        end
        if (burst_end) begin
          cyc_q <= 1'b0;
          stb_q <= 1'b0;
          we_q  <= 1'b0;
          // End of write pass: rewind for the readback pass.
          if (last_word && !rd_q) begin
            rd_q  <= 1'b1;
            off_q <= '0;
            pat_q <= init_q;
          end
        end
      end else if (state_q == S_BUS) begin
        if (to_hit) begin
          cyc_q   <= 1'b0;
          stb_q   <= 1'b0;
          we_q    <= 1'b0;
          error_q <= 1'b1;
        end else begin
          to_cnt_q <= to_cnt_q + TW'(1);
        end
      end
    end
  end

  assign busy_o      = (state_q == S_ARB) || (state_q == S_BUS)
                    || (state_q == S_GAP);
  assign done_o      = (state_q == S_DONE);
  assign error_o     = error_q;
  assign err_count_o = err_cnt_q;
  assign cyc_o       = cyc_q;
  assign stb_o       = stb_q;
  assign we_o        = we_q;
  assign sel_o       = {DATA_BYTES{stb_q}};
  assign adr_o       = cyc_q ? BASE + off_q[ADDRESS_WIDTH-1:0] : '0;
  assign dat_o       = (stb_q && we_q) ? pat_q : '0;

  always_comb begin
    cti_o = 3'b000;
    if (stb_q && burst_q)
      cti_o = (left_q == OW'(1)) ? 3'b111 : 3'b010;
  end

endmodule

// File: tb/tb_wb_pattern_gen.sv
// tb_wb_pattern_gen: RAM-model slave, beat scoreboard, vector table
// and hand sequences for timeout, arbitration and async reset.
module tb_wb_pattern_gen;

  localparam int AW  = 16;
  localparam int DW  = 8;
  localparam int LEN = 16;
  localparam int BL  = 4;
  localparam int TO  = 255;

  logic          clk = 1'b0;
  logic          rst_ni = 1'b0;
  logic          start_i = 1'b0;
  logic [1:0]    mode_i = 2'd0;
  logic          verify_i = 1'b0;
  logic [DW-1:0] seed_i = '0;
  logic          busy_o, done_o, error_o;
  logic [15:0]   err_count_o;
  logic [AW-1:0] adr_o;
  logic [DW-1:0] dat_i, dat_o;
  logic          we_o;
  logic [0:0]    sel_o;
  logic          stb_o;
  logic          cyc_i = 1'b0;
  logic          cyc_o, ack_i;
  logic [2:0]    cti_o;

  always #5 clk = ~clk;

  wb_pattern_gen #(
    .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .BASE_ADDR(0),
    .LENGTH(LEN), .BURST_LEN(BL), .TIMEOUT(TO)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i),
    .mode_i(mode_i), .verify_i(verify_i), .seed_i(seed_i),
    .busy_o(busy_o), .done_o(done_o), .error_o(error_o),
    .err_count_o(err_count_o), .adr_o(adr_o), .dat_i(dat_i),
    .dat_o(dat_o), .we_o(we_o), .sel_o(sel_o), .stb_o(stb_o),
    .cyc_i(cyc_i), .cyc_o(cyc_o), .ack_i(ack_i), .cti_o(cti_o)
  );

  // RAM slave: zero-wait ack, optional corruption of word 5 on read
  logic          ack_en = 1'b1;
  logic          corrupt = 1'b0;
  logic [DW-1:0] mem [0:15];

  assign ack_i = ack_en & cyc_o & stb_o;
  assign dat_i = mem[adr_o[3:0]]
               ^ ((corrupt && adr_o == 16'd5) ? 8'hFF : 8'h00);

  always @(posedge clk)
    if (cyc_o && stb_o && we_o && ack_i)
      mem[adr_o[3:0]] <= dat_o;

  typedef struct packed {
    logic        we;
    logic [15:0] adr;
    logic [7:0]  dat;
    logic [2:0]  cti;
  } beat_t;

  beat_t exp_q[$];

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int gap_cnt = 0;
  int stb_cnt = 0;
  int beat_cnt = 0;

  always @(negedge clk) begin
    beat_t act;
    beat_t exp;
    if (rst_ni) begin
      if (done_o) done_cnt++;
      if (busy_o && !cyc_o) gap_cnt++;
      if (stb_o) stb_cnt++;
      if (cyc_o && stb_o && ack_i) begin
        act = {we_o, adr_o, (we_o ? dat_o : 8'h00), cti_o};
        beat_cnt++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL beat unexpected act=%h", act);
        end else begin
          exp = exp_q.pop_front();
          if (act !== exp || sel_o !== 1'b1) begin
            errors++;
            $display("FAIL beat%0d act=%h sel=%b exp=%h",
                     beat_cnt, act, sel_o, exp);
          end
        end
      end
    end
  end

  function automatic logic [7:0] pat(input logic [1:0] m,
                                     input logic [7:0] s,
                                     input int n);
    logic [7:0] l;
    case (m)
      2'd0: return s + 8'(n);
      2'd1: return (((n % 2) == 0) ? 8'h55 : 8'hAA) ^ s;
      2'd2: begin
        l = (s == 8'h00) ? 8'h01 : s;
        for (int i = 0; i < n; i++)
          l = (l >> 1) ^ (l[0] ? 8'hB8 : 8'h00);
        return l;
      end
      default: return s;
    endcase
  endfunction

  task automatic push_run(input logic [1:0] m, input logic [7:0] s,
                          input logic v);
    logic [2:0] c;
    for (int n = 0; n < LEN; n++) begin
      c = ((n % BL) == BL - 1) ? 3'b111 : 3'b010;
      exp_q.push_back({1'b1, 16'(n), pat(m, s, n), c});
    end
    if (v)
      for (int n = 0; n < LEN; n++) begin
        c = ((n % BL) == BL - 1) ? 3'b111 : 3'b010;
        exp_q.push_back({1'b0, 16'(n), 8'h00, c});
      end
  endtask

  task automatic pulse_start(input logic [1:0] m, input logic [7:0] s,
                             input logic v);
    @(negedge clk); #1;
    done_cnt = 0; gap_cnt = 0; stb_cnt = 0; beat_cnt = 0;
    mode_i = m; seed_i = s; verify_i = v; start_i = 1'b1;
    @(negedge clk); #1;
    start_i = 1'b0;
  endtask

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic wait_done(input int budget, input string tag);
    int n;
    n = 0;
    while (done_cnt == 0 && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    checks++;
    if (done_cnt == 0) begin
      errors++;
      $display("FAIL %s done_o not seen in %0d cycles", tag, budget);
    end
    repeat (2) begin @(negedge clk); #1; end
  endtask

  typedef struct {
    logic [1:0] mode;
    logic       verify;
    logic [7:0] seed;
    logic       corrupt;
    int         exp_errs;
  } vec_t;

  vec_t vt[6];

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int n;
    int hi;
    vt[0] = '{mode: 2'd0, verify: 1'b0, seed: 8'h10, corrupt: 1'b0, exp_errs: 0};
    vt[1] = '{mode: 2'd1, verify: 1'b1, seed: 8'h00, corrupt: 1'b0, exp_errs: 0};
    vt[2] = '{mode: 2'd2, verify: 1'b1, seed: 8'h00, corrupt: 1'b0, exp_errs: 0};
    vt[3] = '{mode: 2'd0, verify: 1'b1, seed: 8'h10, corrupt: 1'b1, exp_errs: 1};
    vt[4] = '{mode: 2'd3, verify: 1'b1, seed: 8'hA5, corrupt: 1'b0, exp_errs: 0};
    vt[5] = '{mode: 2'd2, verify: 1'b1, seed: 8'h5A, corrupt: 1'b1, exp_errs: 1};
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;

    repeat (2) @(negedge clk);
    chk("reset outputs in reset",
        {busy_o, done_o, error_o, err_count_o, adr_o, dat_o,
         we_o, sel_o, stb_o, cyc_o, cti_o}, 64'd0);
    rst_ni = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("idle outputs after reset",
        {busy_o, done_o, error_o, err_count_o, adr_o, dat_o,
         we_o, sel_o, stb_o, cyc_o, cti_o}, 64'd0);

    for (int i = 0; i < 6; i++) begin
      corrupt = vt[i].corrupt;
      push_run(vt[i].mode, vt[i].seed, vt[i].verify);
      pulse_start(vt[i].mode, vt[i].seed, vt[i].verify);
      wait_done(2000, $sformatf("run%0d", i));
      chk($sformatf("run%0d err_count", i), 64'(err_count_o),
          64'(vt[i].exp_errs));
      chk($sformatf("run%0d error", i), 64'(error_o),
          64'(vt[i].exp_errs != 0));
      chk($sformatf("run%0d done pulses", i), 64'(done_cnt), 64'd1);
      chk($sformatf("run%0d cyc low cycles", i), 64'(gap_cnt),
          vt[i].verify ? 64'd8 : 64'd4);
      chk($sformatf("run%0d beats left", i), 64'(exp_q.size()), 64'd0);
    end
    corrupt = 1'b0;

    ack_en = 1'b0;
    pulse_start(2'd0, 8'h00, 1'b1);
    wait_done(600, "timeout");
    chk("timeout stb cycles", 64'(stb_cnt), 64'd255);
    chk("timeout error", 64'(error_o), 64'd1);
    chk("timeout err_count", 64'(err_count_o), 64'd0);
    chk("timeout done pulses", 64'(done_cnt), 64'd1);
    chk("timeout bus idle", {63'd0, cyc_o}, 64'd0);
    ack_en = 1'b1;

    cyc_i = 1'b1;
    push_run(2'd0, 8'h40, 1'b0);
    pulse_start(2'd0, 8'h40, 1'b0);
    hi = 0;
    repeat (20) begin
      @(negedge clk); #1;
      if (cyc_o) hi++;
    end
    chk("cyc_o while cyc_i high", 64'(hi), 64'd0);
    chk("busy while waiting bus", 64'(busy_o), 64'd1);
    cyc_i = 1'b0;
    n = 0;
    while (beat_cnt < 6 && n < 100) begin
      @(negedge clk); #1;
      n++;
    end
    mode_i = 2'd3; start_i = 1'b1;
    @(negedge clk); #1;
    start_i = 1'b0;
    wait_done(2000, "arb");
    chk("arb error cleared", 64'(error_o), 64'd0);
    chk("arb done pulses", 64'(done_cnt), 64'd1);
    chk("arb beats left", 64'(exp_q.size()), 64'd0);

    push_run(2'd1, 8'h00, 1'b0);
    pulse_start(2'd1, 8'h00, 1'b0);
    n = 0;
    while (beat_cnt < 5 && n < 100) begin
      @(negedge clk); #1;
      n++;
    end
    @(posedge clk); #1;
    chk("cyc before reset", 64'(cyc_o), 64'd1);
    #1;
    rst_ni = 1'b0;
    #1;
    chk("async reset outputs",
        {busy_o, done_o, error_o, err_count_o, adr_o, dat_o,
         we_o, sel_o, stb_o, cyc_o, cti_o}, 64'd0);
    exp_q.delete();
    @(negedge clk);
    rst_ni = 1'b1;
    n = beat_cnt;
    repeat (3) @(negedge clk);
    #1;
    chk("idle after reset", {62'd0, busy_o, cyc_o}, 64'd0);
    chk("no beats after reset", 64'(beat_cnt), 64'(n));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_pattern_gen.md
Name: wb_pattern_gen

Overview:
Parametrised Wishbone master that fills a memory region with a selectable test pattern and can optionally read it back and check it. It is the successor to test_pattern, adding configurable width/depth, four pattern modes, incrementing bursts, readback verification and an ack timeout. It sits on the shared pixel/frame-buffer Wishbone bus and is used for bring-up, memory test and LED-matrix fill.

Parameters:
ADDRESS_WIDTH, 16, Wishbone address width (word addresses).
DATA_WIDTH, 8, data width; multiple of 8.
DATA_BYTES, DATA_WIDTH/8, select width.
BASE_ADDR, 0, first word address written.
LENGTH, 256, words per run; 1..2^ADDRESS_WIDTH-BASE_ADDR.
BURST_LEN, 4, beats per burst; 1 = classic cycles only.
LFSR_TAPS, 8'hB8, Galois feedback mask, DATA_WIDTH bits.
TIMEOUT, 255, max cycles a beat waits for ack_i before abort.

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous reset, active low
start_i  in  1  one-cycle pulse; starts a run when idle
mode_i  in  2  0 ramp, 1 checkerboard, 2 LFSR, 3 solid; sampled on start
verify_i  in  1  1 = readback pass after write; sampled on start
seed_i  in  DATA_WIDTH  pattern seed; sampled on start
busy_o  out  1  run in progress
done_o  out  1  one-cycle pulse at run end
error_o  out  1  sticky: mismatch or timeout in last run
err_count_o  out  16  mismatch count, saturating at 16'hFFFF
adr_o  out  ADDRESS_WIDTH  Wishbone address
dat_i  in  DATA_WIDTH  Wishbone read data
dat_o  out  DATA_WIDTH  Wishbone write data
we_o  out  1  write enable
sel_o  out  DATA_BYTES  byte selects, all ones when stb_o
stb_o  out  1  strobe
cyc_i  in  1  another master owns the bus; do not start a cycle while high
cyc_o  out  1  cycle
ack_i  in  1  acknowledge
cti_o  out  3  cycle type identifier

Behaviour:
- Reset (rst_ni low, async): state IDLE; all outputs 0; adr_o=0, cti_o=0; error_o, err_count_o cleared.
- FSM: IDLE -> ARB -> WRITE -> (GAP -> ARB ...) -> READ phase (same ARB/GAP structure, we_o=0) if verify -> DONE -> IDLE.
- start_i in IDLE latches mode, verify, seed (seed 0 with mode 2 replaced by 1); clears error_o/err_count_o; busy_o=1 next cycle. start_i while busy is ignored.
- ARB: wait until cyc_i==0, then assert cyc_o, stb_o, sel_o all ones, adr_o=BASE_ADDR+offset the next cycle.
- Beat completes on clock edge with stb_o&ack_i; offset increments; stb_o stays high for next beat of burst; adr_o/dat_o update same edge.
- Burst = min(BURST_LEN, remaining words). cti_o=3'b010 on all but last beat, 3'b111 on last; BURST_LEN=1 or single remaining word -> cti_o=3'b000.
- After each burst's last ack: cyc_o, stb_o drop for exactly one cycle (GAP), then ARB again.
- Pattern at offset n: mode0 seed+n (mod 2^DATA_WIDTH); mode1 {DATA_BYTES{8'h55}} for even n, {DATA_BYTES{8'hAA}} for odd n, XOR seed; mode2 Galois LFSR advanced once per beat starting at seed, reloaded with seed at READ start; mode3 seed.
- READ: dat_i compared with expected on each ack; mismatch -> err_count_o+1 (saturating), error_o=1. Run always completes all LENGTH reads.
- Timeout: stb_o high without ack_i for TIMEOUT consecutive cycles -> drop cyc_o/stb_o, error_o=1, go to DONE (remaining words skipped).
- DONE: done_o high one cycle, busy_o=0 same cycle; outputs bus idle.
- Last address BASE_ADDR+LENGTH-1 must not wrap; offset counter width ADDRESS_WIDTH+1.
- Reset mid-burst: bus released immediately (async), no further beats.

Test Plan:
- Ramp, seed 8'h10, LENGTH 16, BURST_LEN 4, ack every cycle, verify 0 -> 16 writes adr 0..15, dat 8'h10..8'h1F, cti 010,010,010,111 per burst, cyc_o low 1 cycle between bursts, done_o once, error_o 0.
- Checkerboard seed 0, verify 1, RAM model -> writes 55,AA,...; 16 reads all match, err_count_o 0, error_o 0.
- LFSR seed 0 -> first word 8'h01, then Galois sequence with taps B8; readback matches.
- RAM model corrupts address 5 -> err_count_o=1, error_o=1, all 16 reads still issued.
- ack_i never asserted, TIMEOUT 255 -> cyc_o drops after 255 cycles, error_o=1, done_o pulses.
- cyc_i held high 20 cycles after start -> cyc_o stays 0 until cyc_i falls; rst_ni pulsed mid-burst -> all outputs 0 asynchronously.
